// File: rtl/spi_slave_reg_cmd.sv
// -----------------------------------------------------------------------------
// spi_slave_reg_cmd
//
// Command front-end for the SPI slave configuration register file. Bytes are
// shifted in on sdi (one bit per sclk in SPI mode, one nibble per sclk in QPI
// mode, MSB first), the first byte is decoded as a register command, and the
// register file's write and read ports are driven accordingly. Read data is
// serialised back to the master on sdo.
//
// Commands:
//   0x70-0x73  write register cmd[1:0] with the following data byte
//   0x60-0x63  read register cmd[1:0]; one turnaround cycle, then data out
//   others     cmd_err pulse, rest of the transaction ignored
//
// Ports:
//   sclk           SPI clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   cs_n           chip select, active low
//   sdi[3:0]       serial data in (SPI uses sdi[0], QPI uses all four lanes)
//   en_qpi         QPI enable from the register file, latched per transaction
//   rd_data        register file read data (combinational on rd_addr)
//   rd_addr        register file read address, held between transactions
//   wr_data        register file write data
//   wr_addr        register file write address
//   wr_data_valid  one-cycle write strobe
//   sdo[3:0]       serial data out (SPI uses sdo[1], QPI uses all four lanes)
//   sdo_oe[3:0]    per-lane output enable
//   cmd_err        one-cycle pulse on an unrecognised command byte
//   busy           high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module spi_slave_reg_cmd #(
  parameter int REG_SIZE = 8
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic                cs_n,
  input  logic [3:0]          sdi,
  input  logic                en_qpi,
  input  logic [REG_SIZE-1:0] rd_data,
  output logic [1:0]          rd_addr,
  output logic [REG_SIZE-1:0] wr_data,
  output logic [1:0]          wr_addr,
  output logic                wr_data_valid,
  output logic [3:0]          sdo,
  output logic [3:0]          sdo_oe,
  output logic                cmd_err,
  output logic                busy
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    TURN,
    RDATA,
    DONE
  } state_t;

  state_t              state;
  logic                qpi_q;
  logic [1:0]          addr_q;
  logic [2:0]          cnt;
  logic [REG_SIZE-1:0] rx_shift;
  logic [REG_SIZE-1:0] tx_shift;

  logic                mode;
  logic [REG_SIZE-1:0] rx_next;
  logic                rx_last;
  logic                tx_last;

  // The mode is latched on the very edge that takes the first sample, so that
  // sample has to be shifted using en_qpi directly rather than qpi_q.
  always_comb begin
    mode    = (state == IDLE) ? en_qpi : qpi_q;
    rx_next = mode ? {rx_shift[REG_SIZE-5:0], sdi} : {rx_shift[REG_SIZE-2:0], sdi[0]};
    rx_last = mode ? (cnt == 3'd1) : (cnt == 3'd7);
    tx_last = qpi_q ? (cnt == 3'd1) : (cnt == 3'd7);
  end

  assign busy = (state != IDLE);

  // Main transaction FSM. The first read symbol is loaded onto sdo at the
  // TURN edge, so tx_shift holds only the symbols still to be sent.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state         <= IDLE;
      qpi_q         <= 1'b0;
      addr_q        <= 2'd0;
      cnt           <= 3'd0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      rd_addr       <= 2'd0;
      wr_data       <= '0;
      wr_addr       <= 2'd0;
      wr_data_valid <= 1'b0;
      sdo           <= 4'd0;
      sdo_oe        <= 4'd0;
      cmd_err       <= 1'b0;
    end else begin
      wr_data_valid <= 1'b0;
      cmd_err       <= 1'b0;
      if (cs_n) begin
        state    <= IDLE;
        cnt      <= 3'd0;
        rx_shift <= '0;
        sdo      <= 4'd0;
        sdo_oe   <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            qpi_q    <= en_qpi;
            rx_shift <= rx_next;
            cnt      <= 3'd1;
            state    <= CMD;
          end
          CMD: begin
            if (rx_last) begin
              cnt      <= 3'd0;
              rx_shift <= '0;
              if (rx_next[7:2] == 6'b011100) begin
                addr_q <= rx_next[1:0];
                state  <= WDATA;
              end else if (rx_next[7:2] == 6'b011000) begin
                rd_addr <= rx_next[1:0];
                state   <= TURN;
              end else begin
                cmd_err <= 1'b1;
                state   <= DONE;
              end
            end else begin
              rx_shift <= rx_next;
              cnt      <= cnt + 3'd1;
            end
          end
          WDATA: begin
            if (rx_last) begin
              wr_data       <= rx_next;
              wr_addr       <= addr_q;
              wr_data_valid <= 1'b1;
              cnt           <= 3'd0;
              rx_shift      <= '0;
              state         <= DONE;
            end else begin
              rx_shift <= rx_next;
              cnt      <= cnt + 3'd1;
            end
          end
          TURN: begin
            cnt   <= 3'd0;
            state <= RDATA;
            if (qpi_q) begin
              sdo      <= rd_data[7:4];
              sdo_oe   <= 4'b1111;
              tx_shift <= {rd_data[3:0], 4'b0000};
            end else begin
              sdo      <= {2'b00, rd_data[7], 1'b0};
              sdo_oe   <= 4'b0010;
              tx_shift <= {rd_data[6:0], 1'b0};
            end
          end
          RDATA: begin
            if (tx_last) begin
              sdo    <= 4'd0;
              sdo_oe <= 4'd0;
              cnt    <= 3'd0;
              state  <= DONE;
            end else begin
              cnt <= cnt + 3'd1;
              if (qpi_q) begin
                sdo      <= tx_shift[7:4];
                tx_shift <= {tx_shift[3:0], 4'b0000};
              end else begin
                sdo      <= {2'b00, tx_shift[7], 1'b0};
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          DONE: begin
            sdo    <= 4'd0;
            sdo_oe <= 4'd0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_cmd.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_reg_cmd
//
// Bench for spi_slave_reg_cmd. The bench plays both the SPI master and the
// register file. Each transaction pushes the responses the block should give
// (write strobes, command errors, read symbols) into a scoreboard queue; a
// monitor on the falling edge pops and compares whenever the block presents
// one of those outputs. The expected register contents are kept in a separate
// array updated from the transactions the bench issues.
// -----------------------------------------------------------------------------
module tb_spi_slave_reg_cmd;

  localparam int EV_WR  = 0;
  localparam int EV_ERR = 1;
  localparam int EV_RD  = 2;

  localparam int K_WRITE = 0;
  localparam int K_READ  = 1;
  localparam int K_BAD   = 2;
  localparam int K_ABORT = 3;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  logic       sclk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic [3:0] sdi;
  logic       en_qpi;
  logic [7:0] rd_data;
  logic [1:0] rd_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_addr;
  logic       wr_data_valid;
  logic [3:0] sdo;
  logic [3:0] sdo_oe;
  logic       cmd_err;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  ev_t  sbq[$];
  bit   mon_en = 1'b0;
  bit   toggle_en = 1'b0;
  bit   tog_ok = 1'b0;
  logic load_rf;

  logic [7:0] init_regs [4];
  logic [7:0] rf [4];
  logic [7:0] model [4];

  spi_slave_reg_cmd #(.REG_SIZE(8)) dut (
    .sclk          (sclk),
    .rst           (rst),
    .cs_n          (cs_n),
    .sdi           (sdi),
    .en_qpi        (en_qpi),
    .rd_data       (rd_data),
    .rd_addr       (rd_addr),
    .wr_data       (wr_data),
    .wr_addr       (wr_addr),
    .wr_data_valid (wr_data_valid),
    .sdo           (sdo),
    .sdo_oe        (sdo_oe),
    .cmd_err       (cmd_err),
    .busy          (busy)
  );

  always #5 sclk = ~sclk;

  // Register file stand-in: combinational read, write on the edge after the strobe.
  assign rd_data = rf[rd_addr];
  always @(posedge sclk) begin
    if (load_rf) begin
      for (int i = 0; i < 4; i++) rf[i] <= init_regs[i];
    end else if (wr_data_valid) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic handleEvent(input int kind, input logic [15:0] val);
    ev_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_event: actual kind=%0d val=%0h expected none", kind, val);
    end else begin
      e = sbq.pop_front();
      checkOutput("sb_kind", 16'(kind), 16'(e.kind));
      checkOutput("sb_value", val, e.val);
    end
  endtask

  // Monitor: compares whatever the block presents against the scoreboard.
  always @(negedge sclk) begin
    if (mon_en && !rst) begin
      if (wr_data_valid) handleEvent(EV_WR, {6'b0, wr_addr, wr_data});
      if (cmd_err) handleEvent(EV_ERR, 16'h0000);
      if (sdo_oe != 4'b0000) handleEvent(EV_RD, {8'h00, sdo_oe, sdo});
    end
  end

  task automatic pushEvent(input int kind, input logic [15:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sbq.push_back(e);
  endtask

  // One sclk: the given values are sampled on the next rising edge.
  task automatic step(input logic cs, input logic [3:0] d);
    @(posedge sclk);
    #1;
    if (tog_ok) en_qpi = ~en_qpi;
    cs_n   = cs;
    sdi    = d;
    tog_ok = toggle_en;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit qpi);
    if (qpi) begin
      step(1'b0, b[7:4]);
      step(1'b0, b[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) step(1'b0, {3'($urandom), b[i]});
    end
  endtask

  // Issues one complete transaction and records the expected responses.
  // For K_BAD, data is the command byte; for K_ABORT, nsamp data samples are
  // sent before cs_n rises.
  task automatic applyStimulus(input int kind, input bit qpi, input logic [1:0] addr,
                               input logic [7:0] data, input int nsamp);
    logic [7:0] v;
    tog_ok = 1'b0;
    en_qpi = qpi;
    case (kind)
      K_WRITE: begin
        pushEvent(EV_WR, {6'b0, addr, data});
        model[addr] = data;
        sendByte({6'b011100, addr}, qpi);
        sendByte(data, qpi);
        step(1'b0, 4'($urandom));
      end
      K_READ: begin
        v = model[addr];
        if (qpi) begin
          pushEvent(EV_RD, {8'h00, 4'hF, v[7:4]});
          pushEvent(EV_RD, {8'h00, 4'hF, v[3:0]});
        end else begin
          for (int i = 7; i >= 0; i--) pushEvent(EV_RD, {8'h00, 4'b0010, 2'b00, v[i], 1'b0});
        end
        sendByte({6'b011000, addr}, qpi);
        repeat (qpi ? 3 : 9) step(1'b0, 4'($urandom));
      end
      K_BAD: begin
        pushEvent(EV_ERR, 16'h0000);
        sendByte(data, qpi);
        repeat ($urandom_range(0, 3)) step(1'b0, 4'($urandom));
      end
      default: begin
        sendByte({6'b011100, addr}, qpi);
        if (qpi) begin
          step(1'b0, 4'($urandom));
        end else begin
          repeat (nsamp) step(1'b0, 4'($urandom));
        end
      end
    endcase
    step(1'b1, 4'd0);
    tog_ok    = 1'b0;
    toggle_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] bad;
    int         kind;
    rst     = 1'b1;
    cs_n    = 1'b1;
    sdi     = 4'd0;
    en_qpi  = 1'b0;
    load_rf = 1'b1;
    for (int i = 0; i < 4; i++) init_regs[i] = 8'($urandom);
    init_regs[1] = 8'h20;
    for (int i = 0; i < 4; i++) model[i] = init_regs[i];
    repeat (3) @(posedge sclk);
    #1;
    rst     = 1'b0;
    load_rf = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_rd_addr", 16'(rd_addr), 16'h0);
    checkOutput("rst_wr_data", 16'(wr_data), 16'h0);
    checkOutput("rst_wr_addr", 16'(wr_addr), 16'h0);
    checkOutput("rst_wr_valid", 16'(wr_data_valid), 16'h0);
    checkOutput("rst_sdo", 16'(sdo), 16'h0);
    checkOutput("rst_sdo_oe", 16'(sdo_oe), 16'h0);
    checkOutput("rst_cmd_err", 16'(cmd_err), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    mon_en = 1'b1;

    $display("[TB] SPI write 0x71 / 0x0A");
    en_qpi = 1'b0;
    pushEvent(EV_WR, {6'b0, 2'd1, 8'h0A});
    model[1] = 8'h0A;
    sendByte(8'h71, 1'b0);
    sendByte(8'h0A, 1'b0);
    step(1'b0, 4'd0);
    checkOutput("wr_strobe_on", 16'(wr_data_valid), 16'h1);
    checkOutput("wr_strobe_addr", 16'(wr_addr), 16'h1);
    checkOutput("wr_strobe_data", 16'(wr_data), 16'h0A);
    step(1'b1, 4'd0);
    checkOutput("wr_strobe_off", 16'(wr_data_valid), 16'h0);
    step(1'b1, 4'd0);

    $display("[TB] SPI read reg1 = 0x20");
    applyStimulus(K_WRITE, 1'b0, 2'd1, 8'h20, 0);
    applyStimulus(K_READ, 1'b0, 2'd1, 8'h00, 0);
    checkOutput("rd_addr_hold", 16'(rd_addr), 16'h1);

    $display("[TB] QPI write/read reg2 = 0xA5");
    applyStimulus(K_WRITE, 1'b1, 2'd2, 8'hA5, 0);
    applyStimulus(K_READ, 1'b1, 2'd2, 8'h00, 0);
    checkOutput("rd_addr_qpi", 16'(rd_addr), 16'h2);

    $display("[TB] mode latch");
    toggle_en = 1'b1;
    applyStimulus(K_WRITE, 1'b0, 2'd0, 8'h01, 0);
    applyStimulus(K_READ, 1'b1, 2'd0, 8'h00, 0);

    $display("[TB] bad command 0x55");
    applyStimulus(K_BAD, 1'b0, 2'd0, 8'h55, 0);

    $display("[TB] abort after 4 data bits");
    applyStimulus(K_ABORT, 1'b0, 2'd3, 8'h00, 4);
    step(1'b1, 4'd0);
    checkOutput("abort_busy", 16'(busy), 16'h0);
    checkOutput("abort_no_strobe", 16'(wr_data_valid), 16'h0);

    $display("[TB] reset during read data");
    mon_en = 1'b0;
    en_qpi = 1'b0;
    sendByte(8'h63, 1'b0);
    repeat (4) step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    checkOutput("pre_rst_sdo_oe", 16'(sdo_oe), 16'b0010);
    rst = 1'b1;
    step(1'b0, 4'd0);
    checkOutput("midrst_rd_addr", 16'(rd_addr), 16'h0);
    checkOutput("midrst_sdo", 16'(sdo), 16'h0);
    checkOutput("midrst_sdo_oe", 16'(sdo_oe), 16'h0);
    checkOutput("midrst_busy", 16'(busy), 16'h0);
    checkOutput("midrst_cmd_err", 16'(cmd_err), 16'h0);
    checkOutput("midrst_wr_valid", 16'(wr_data_valid), 16'h0);
    rst  = 1'b0;
    cs_n = 1'b1;
    step(1'b1, 4'd0);
    mon_en = 1'b1;

    $display("[TB] randomized transactions");
    for (int t = 0; t < 60; t++) begin
      kind      = int'($urandom_range(0, 3));
      toggle_en = 1'($urandom);
      if (kind == K_BAD) begin
        do bad = 8'($urandom); while (bad[7:2] == 6'b011100 || bad[7:2] == 6'b011000);
        applyStimulus(K_BAD, 1'($urandom), 2'd0, bad, 0);
      end else begin
        applyStimulus(kind, 1'($urandom), 2'($urandom), 8'($urandom),
                      int'($urandom_range(1, 7)));
      end
      repeat ($urandom_range(0, 2)) step(1'b1, 4'd0);
    end

    for (int a = 0; a < 4; a++) applyStimulus(K_READ, 1'($urandom), 2'(a), 8'h00, 0);

    repeat (5) step(1'b1, 4'd0);
    checkOutput("sb_drain", 16'(sbq.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
